alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Pipelined, parametrised successor of the single-stage datapath ALU. It adds a valid/ready
//  handshake on both sides, two register stages with full backpressure, and four new ops
//  (SLTU, OR, XOR, shifts). Flags are registered with their result, plus a sticky overflow.
//  Sits between the register-file read port and writeback. Opcodes 0-7 keep the legacy encoding.
// PARAMETERS
//  WIDTH    32  operand/result width in bits, >= 2
//  OP_W     4   opcode width; codes >= 14 are reserved
//  SHAMT_W  $clog2(WIDTH)  shift amount bits taken from b[SHAMT_W-1:0]
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  in_valid    in   1       operand/opcode valid
//  in_ready    out  1       block can accept this cycle
//  in_a        in   WIDTH   operand A (legacy R2)
//  in_b        in   WIDTH   operand B (legacy R3)
//  in_op       in   OP_W    opcode
//  out_valid   out  1       result valid
//  out_ready   in   1       downstream accepts result
//  out_result  out  WIDTH   result
//  out_carry   out  1       carry flag of this result
//  out_ovf     out  1       signed overflow flag of this result
//  out_zero    out  1       out_result == 0
//  out_illegal out  1       reserved opcode was issued
//  ovf_sticky  out  1       set by any transferred result with out_ovf=1
//  sticky_clr  in   1       clears ovf_sticky
// BEHAVIOUR
//  - Reset: out_valid=0, ovf_sticky=0, result/flags=0, stage valids=0. in_ready=1 from the first
//    cycle after reset. Any in-flight op is discarded when rst is asserted mid-operation.
//  - Opcodes: 0 MOV a | 1 NOT a | 2 ADD | 3 NOR | 4 SUB a-b | 5 NAND | 6 AND | 7 SLT signed
//    | 8 SLTU | 9 OR | 10 XOR | 11 SLL | 12 SRL | 13 SRA | 14,15 reserved.
//  - Reserved opcode: result=0, all arithmetic flags=0, out_illegal=1. It still flows through the pipe.
//  - ADD: carry = unsigned carry-out; ovf = signed overflow. SUB is computed as a+~b+1.
//    Its carry = carry-out of that sum (1 = no borrow, i.e. a>=b unsigned); ovf = signed overflow.
//  - For every other op, carry=0 and ovf=0. SLT/SLTU return 0 or 1 zero-extended to WIDTH.
//  - Shift amounts >= WIDTH are impossible: only SHAMT_W bits are used. SRA replicates a[WIDTH-1].
//  - zero is computed from the registered result in the same stage, never from the previous op.
//  - Pipeline: S1 registers op/operands; S2 registers the result and flags from alu_core.
//    Stage enables: en2 = !v2 | out_ready; en1 = !v1 | en2; in_ready = en1 (combinational).
//  - Transfer happens on in_valid&in_ready and on out_valid&out_ready.
//  - Latency: accepted op reaches out_valid exactly 2 cycles later when not stalled.
//    Throughput is 1 op/cycle.
//  - Stall: while out_valid & !out_ready, out_* hold stable. Up to 2 ops are buffered and none
//    is lost or duplicated. Order is strictly FIFO.
//  - Sticky: ovf_sticky <= (ovf_sticky & !sticky_clr) | (out_valid&out_ready&out_ovf).
//    When clear and set happen in the same cycle, set wins.
// STRUCTURE
//  - alu_pkg: opcode localparams (OP_MOV..OP_SRA), OP_W, reserved-range constant. These are
//    shared with the decoder.
//  - One sub-module, alu_core: purely combinational. It maps a, b, op to result, carry, ovf,
//    illegal. alu_pipe owns all registers and the handshake.
// TESTING
//  - Reset/idle: rst 1 for 2 cycles -> out_valid=0, ovf_sticky=0, in_ready=1 on release.
//  - ADD WIDTH=32: 0xFFFFFFFF+1 -> result 0, carry=1, zero=1, ovf=0, valid at cycle+2.
//    0x7FFFFFFF+1 -> 0x80000000, ovf=1.
//  - SUB/SLT: 5-7 -> 0xFFFFFFFE, carry=0. 7-5 -> 2, carry=1.
//    SLT(-1,1)=1 and SLTU(0xFFFFFFFF,1)=0.
//  - Shifts/reserved: SRA 0x80000000 by 4 -> 0xF8000000. SRL -> 0x08000000.
//    op 14 -> result 0, illegal=1.
//  - Backpressure: stream 8 ops with out_ready toggling randomly and at 0 for 5 cycles.
//    Required: in_ready drops after 2 buffered ops, outputs hold, all 8 results arrive in order,
//    no duplicates.
//  - Sticky: an overflowing ADD transferred out -> ovf_sticky=1. Assert sticky_clr in the same
//    cycle as another overflow transfer -> stays 1. A lone sticky_clr -> 0 the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default opcode width and the
// reserved-opcode boundary. Also used by the instruction decoder.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  // Opcodes 0-7 keep the legacy single-stage ALU encoding.
  localparam int unsigned OP_MOV  = 0;
  localparam int unsigned OP_NOT  = 1;
  localparam int unsigned OP_ADD  = 2;
  localparam int unsigned OP_NOR  = 3;
  localparam int unsigned OP_SUB  = 4;
  localparam int unsigned OP_NAND = 5;
  localparam int unsigned OP_AND  = 6;
  localparam int unsigned OP_SLT  = 7;
  localparam int unsigned OP_SLTU = 8;
  localparam int unsigned OP_OR   = 9;
  localparam int unsigned OP_XOR  = 10;
  localparam int unsigned OP_SLL  = 11;
  localparam int unsigned OP_SRL  = 12;
  localparam int unsigned OP_SRA  = 13;

  // Every code at or above this value is reserved.
  localparam int unsigned OP_RSVD_MIN = 14;

  function automatic logic is_reserved(input int unsigned op);
    return op >= OP_RSVD_MIN;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath.
// Ports: a, b     - operands
//        op       - opcode (alu_pkg encoding)
//        result_c - result, zero for reserved opcodes
//        carry_c  - carry-out for ADD/SUB, else 0
//        ovf_c    - signed overflow for ADD/SUB, else 0
//        illegal_c- reserved opcode
module alu_core #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result_c,
  output logic             carry_c,
  output logic             ovf_c,
  output logic             illegal_c
);
  import alu_pkg::*;

  logic [WIDTH:0]       add_full;
  logic [WIDTH:0]       sub_full;
  logic [SHAMT_W-1:0]   shamt;

  assign add_full = {1'b0, a} + {1'b0, b};
  // Subtract as a + ~b + 1 so the carry-out reads as "no borrow".
  assign sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign shamt    = b[SHAMT_W-1:0];

  // Opcode decode and flag generation
  always_comb begin
    result_c  = '0;
    carry_c   = 1'b0;
    ovf_c     = 1'b0;
    illegal_c = (op >= OP_W'(OP_RSVD_MIN));
    case (op)
      OP_W'(OP_MOV):  result_c = a;
      OP_W'(OP_NOT):  result_c = ~a;
      OP_W'(OP_ADD): begin
        result_c = add_full[WIDTH-1:0];
        carry_c  = add_full[WIDTH];
        ovf_c    = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_W'(OP_NOR):  result_c = ~(a | b);
      OP_W'(OP_SUB): begin
        result_c = sub_full[WIDTH-1:0];
        carry_c  = sub_full[WIDTH];
        ovf_c    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_W'(OP_NAND): result_c = ~(a & b);
      OP_W'(OP_AND):  result_c = a & b;
      OP_W'(OP_SLT):  result_c = WIDTH'($signed(a) < $signed(b));
      OP_W'(OP_SLTU): result_c = WIDTH'(a < b);
      OP_W'(OP_OR):   result_c = a | b;
      OP_W'(OP_XOR):  result_c = a ^ b;
      OP_W'(OP_SLL):  result_c = a << shamt;
      OP_W'(OP_SRL):  result_c = a >> shamt;
      OP_W'(OP_SRA):  result_c = WIDTH'($signed(a) >>> shamt);
      default:        result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides.
// S1 registers opcode/operands, S2 registers result and flags from alu_core.
// Ports: clk, rst (sync, active high)
//        in_valid/in_ready, in_a, in_b, in_op   - operand side
//        out_valid/out_ready, out_result, out_carry, out_ovf,
//        out_zero, out_illegal                  - result side
//        ovf_sticky, sticky_clr                 - accumulated overflow flag
module alu_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OP_W    = alu_pkg::OP_W,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_illegal,
  output logic             ovf_sticky,
  input  logic             sticky_clr
);
  import alu_pkg::*;

  logic             v1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [OP_W-1:0]  op1;
  logic             en1;
  logic             en2;

  logic [WIDTH-1:0] core_result_c;
  logic             core_carry_c;
  logic             core_ovf_c;
  logic             core_illegal_c;

  // Stage enables: a stage advances when empty or when the next one advances.
  assign en2      = !out_valid || out_ready;
  assign en1      = !v1 || en2;
  assign in_ready = en1;

  alu_core #(
    .WIDTH   (WIDTH),
    .OP_W    (OP_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .a         (a1),
    .b         (b1),
    .op        (op1),
    .result_c  (core_result_c),
    .carry_c   (core_carry_c),
    .ovf_c     (core_ovf_c),
    .illegal_c (core_illegal_c)
  );

  // S1: operand/opcode register
  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      op1 <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1  <= in_a;
        b1  <= in_b;
        op1 <= in_op;
      end
    end
  end

  // S2: result/flag register; zero is derived from the result being captured
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_carry   <= 1'b0;
      out_ovf     <= 1'b0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (en2) begin
      out_valid <= v1;
      if (v1) begin
        out_result  <= core_result_c;
        out_carry   <= core_carry_c;
        out_ovf     <= core_ovf_c;
        out_zero    <= (core_result_c == '0);
        out_illegal <= core_illegal_c;
      end
    end
  end

  // Sticky overflow: a transfer with overflow wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= (ovf_sticky && !sticky_clr) || (out_valid && out_ready && out_ovf);
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned SHAMT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;
  logic             out_illegal;
  logic             ovf_sticky;
  logic             sticky_clr;

  alu_pipe #(.WIDTH(WIDTH), .OP_W(OP_W), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_illegal(out_illegal),
    .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             illegal;
  } exp_t;

  exp_t exp_q[$];
  exp_t pending;
  exp_t held;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  logic s_in_ready;
  logic s_out_valid;
  logic stall_prev = 1'b0;
  logic rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model, written from the opcode table with 64-bit arithmetic
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t   e;
    longint sa;
    longint sbv;
    longint r;
    int     sh;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    sh  = int'(b[4:0]);
    e   = '0;
    case (op)
      4'd0:  e.result = a;
      4'd1:  e.result = ~a;
      4'd2: begin
        e.result = a + b;
        e.carry  = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
        r        = sa + sbv;
        e.ovf    = r != longint'($signed(e.result));
      end
      4'd3:  e.result = ~(a | b);
      4'd4: begin
        e.result = a - b;
        e.carry  = a >= b;
        r        = sa - sbv;
        e.ovf    = r != longint'($signed(e.result));
      end
      4'd5:  e.result = ~(a & b);
      4'd6:  e.result = a & b;
      4'd7:  e.result = (sa < sbv) ? 32'd1 : 32'd0;
      4'd8:  e.result = (a < b) ? 32'd1 : 32'd0;
      4'd9:  e.result = a | b;
      4'd10: e.result = a ^ b;
      4'd11: e.result = a << sh;
      4'd12: e.result = a >> sh;
      4'd13: e.result = (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] res, input logic c, input logic o, input logic ill);
    exp_t e;
    e.result  = res;
    e.carry   = c;
    e.ovf     = o;
    e.zero    = (res == 32'd0);
    e.illegal = ill;
    return e;
  endfunction

  // One clock: sample at negedge, score transfers, advance past posedge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    if (stall_prev) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_outputs", 64'({out_result, out_carry, out_ovf, out_zero, out_illegal}), 64'(held));
    end
    if (in_valid && in_ready && !rst) exp_q.push_back(pending);
    if (out_valid && out_ready && !rst) begin
      n_out++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_out: observed result %0h expected no output", out_result);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result",  64'(out_result),  64'(e.result));
        chk("carry",   64'(out_carry),   64'(e.carry));
        chk("ovf",     64'(out_ovf),     64'(e.ovf));
        chk("zero",    64'(out_zero),    64'(e.zero));
        chk("illegal", 64'(out_illegal), 64'(e.illegal));
      end
    end
    stall_prev = out_valid && !out_ready && !rst;
    held       = {out_result, out_carry, out_ovf, out_zero, out_illegal};
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input exp_t e);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_a = a; in_b = b; in_op = op; pending = e; in_valid = 1'b1;
    while (!acc && n < 50) begin
      tick();
      acc = s_in_ready;
      n++;
    end
    chk("accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra[8];
    logic [31:0] rb[8];
    logic [3:0]  rop[8];
    int          n0;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b1; sticky_clr = 1'b0; pending = '0;

    // Reset / idle
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sticky", 64'(ovf_sticky), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 64'(s_in_ready), 64'd1);
    chk("idle_out_valid", 64'(s_out_valid), 64'd0);

    // ADD wrap with latency check
    issue(32'hFFFF_FFFF, 32'd1, 4'd2, mk(32'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("lat_cycle1", 64'(s_out_valid), 64'd0);
    tick();
    chk("lat_cycle2", 64'(s_out_valid), 64'd1);
    chk("lat_popped", 64'(exp_q.size()), 64'd0);

    // Directed back-to-back stream
    issue(32'h7FFF_FFFF, 32'd1, 4'd2,  mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    issue(32'd5, 32'd7, 4'd4,          mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    issue(32'd7, 32'd5, 4'd4,          mk(32'd2, 1'b1, 1'b0, 1'b0));
    issue(32'd5, 32'd5, 4'd4,          mk(32'd0, 1'b1, 1'b0, 1'b0));
    issue(32'h8000_0000, 32'd1, 4'd4,  mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    issue(32'hFFFF_FFFF, 32'd1, 4'd7,  mk(32'd1, 1'b0, 1'b0, 1'b0));
    issue(32'hFFFF_FFFF, 32'd1, 4'd8,  mk(32'd0, 1'b0, 1'b0, 1'b0));
    issue(32'h8000_0000, 32'd4, 4'd13, mk(32'hF800_0000, 1'b0, 1'b0, 1'b0));
    issue(32'h8000_0000, 32'd4, 4'd12, mk(32'h0800_0000, 1'b0, 1'b0, 1'b0));
    issue(32'h0000_0001, 32'h24, 4'd11, mk(32'h0000_0010, 1'b0, 1'b0, 1'b0));
    issue(32'h0000_0001, 32'd31, 4'd11, mk(32'h8000_0000, 1'b0, 1'b0, 1'b0));
    issue(32'h1234_5678, 32'd3, 4'd14, mk(32'd0, 1'b0, 1'b0, 1'b1));
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, mk(32'd0, 1'b0, 1'b0, 1'b1));
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd10, mk(32'hFF00_FF00, 1'b0, 1'b0, 1'b0));
    issue(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd3,  mk(32'd0, 1'b0, 1'b0, 1'b0));
    drain(50);
    chk("sticky_set", 64'(ovf_sticky), 64'd1);

    // Clear coinciding with an overflow transfer: set wins
    issue(32'h7FFF_FFFF, 32'd1, 4'd2, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    tick();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky_fire", 64'(s_out_valid), 64'd1);
    chk("sticky_clr_vs_set", 64'(ovf_sticky), 64'd1);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky_lone_clr", 64'(ovf_sticky), 64'd0);

    // Reset mid-operation discards the in-flight op
    issue(32'h7FFF_FFFF, 32'd1, 4'd2, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_sticky", 64'(ovf_sticky), 64'd0);
    tick();
    chk("midrst_idle1", 64'(s_out_valid), 64'd0);
    tick();
    chk("midrst_idle2", 64'(s_out_valid), 64'd0);

    // Backpressure: 8 ops, 5-cycle stall, then random ready
    for (int i = 0; i < 8; i++) begin
      ra[i]  = (i % 3 == 0) ? 32'hFFFF_FFFF : $urandom;
      rb[i]  = $urandom;
      rop[i] = 4'($urandom_range(0, 15));
    end
    n0 = n_out;
    out_ready = 1'b0;
    issue(ra[0], rb[0], rop[0], model(ra[0], rb[0], rop[0]));
    issue(ra[1], rb[1], rop[1], model(ra[1], rb[1], rop[1]));
    in_a = ra[2]; in_b = rb[2]; in_op = rop[2];
    pending = model(ra[2], rb[2], rop[2]);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_in_ready_low", 64'(s_in_ready), 64'd0);
    end
    rand_ready = 1'b1;
    out_ready  = 1'b1;
    for (int i = 2; i < 8; i++) issue(ra[i], rb[i], rop[i], model(ra[i], rb[i], rop[i]));
    drain(200);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    chk("bp_count", 64'(n_out - n0), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
